cfg_access_initiator: RTL
=========================

# cfg_access_initiator

CSR-programmable Avalon-MM initiator that issues single root-port configuration-space reads and writes into the P-tile config slave (cs_* interface) on behalf of software on the HPS lightweight bridge. It launches one command per GO, tracks the acceptance and response handshakes, and enforces a programmable timeout. On timeout it completes locally with an all-ones/error result so software never hangs. Status and read data are returned through the same CSR interface.

## Interface
- ADDR_WIDTH, 14, config slave address width
- DATA_WIDTH, 32, config data width
- RESP_WIDTH, 2, Avalon response width
- CSR_ADDR_WIDTH, 8, CSR word-address width
- CSR_DATA_WIDTH, 32, CSR data width
- TIMEOUT_CYCLES, 65535, reset value of TO_LIMIT (16 bits used)

Ports:
- clk_i  in  1  sole clock
- rstn_i  in  1  reset; asynchronous assert, active-low
- csr_address_i  in  CSR_ADDR_WIDTH  CSR word index
- csr_read_i / csr_write_i  in  1  CSR strobes
- csr_writedata_i  in  CSR_DATA_WIDTH  CSR write data
- csr_byteenable_i  in  CSR_DATA_WIDTH/8  ignored; full-word access only
- csr_readdata_o  out  CSR_DATA_WIDTH  CSR read data
- csr_readdatavalid_o  out  1  CSR read data valid
- csr_waitrequest_o  out  1  constant 0
- cs_address_o  out  ADDR_WIDTH  config address
- cs_writedata_o  out  DATA_WIDTH  config write data
- cs_read_o / cs_write_o  out  1  config command strobes
- cs_byteenable_o  out  DATA_WIDTH/8  config byte enables
- cs_burstcount_o  out  1  constant 1
- cs_waitrequest_i  in  1  slave stall
- cs_readdatavalid_i / cs_writerespvalid_i  in  1  slave responses
- cs_readdata_i  in  DATA_WIDTH  slave read data
- cs_resp_i  in  RESP_WIDTH  slave response code
- done_o  out  1  one-cycle pulse on every completion (normal or timeout)

## Operation
- CSR map (word index): 0 ADDR RW [13:0]; 1 WDATA RW; 2 CTRL WO: bit0 GO, bit1 RNW (1=read), bits[7:4] BE; 3 STATUS RO/W1C: bit0 BUSY, bit1 DONE (W1C), bit2 TIMEOUT (W1C), bit3 GO_ERR (W1C), [5:4] RESP, [15:8] STRAY count (saturating at 255, cleared by writing bit16=1); 4 RDATA RO; 5 TO_LIMIT RW [15:0]. Unmapped reads return 0; unmapped writes are dropped.
- Writes to ADDR/WDATA/TO_LIMIT while BUSY are dropped.
- GO while BUSY: command ignored, GO_ERR set.
- GO while idle: latches RNW and BE, clears DONE/TIMEOUT/RESP, clears timeout counter, sets BUSY.
- FSM: IDLE -> REQ on GO. In REQ, cs_read_o or cs_write_o is held with ADDR/WDATA/BE until a cycle with cs_waitrequest_i=0, then -> RESP. RESP waits for cs_readdatavalid_i (read) or cs_writerespvalid_i (write); on it RDATA<=cs_readdata_i (reads only), RESP<=cs_resp_i, then -> DONE. DONE lasts one cycle, pulses done_o, clears BUSY, sets DONE, -> IDLE.
- Timeout: 16-bit counter increments every cycle in REQ and RESP. When the counter equals TO_LIMIT and no qualifying response is present that cycle, set TIMEOUT, RESP=2'b10, RDATA=32'hFFFF_FFFF (reads only), and go -> DONE. A timeout in REQ drops the command strobe, and this violation is deliberate. TO_LIMIT=0 behaves as 1.
- Stray: any cs_readdatavalid_i or cs_writerespvalid_i seen in IDLE, REQ or DONE, or a non-matching response type in RESP, increments STRAY and is otherwise ignored.
- Response and timeout in the same cycle: the response wins.
- Reset mid-operation: all state returns to reset values and strobes drop immediately. Any later response is counted as stray.

## Timing
- Reset values: every cs_* output 0 except cs_burstcount_o=1; csr_readdata_o=0, csr_readdatavalid_o=0, done_o=0; ADDR/WDATA/STATUS/RDATA=0, TO_LIMIT=TIMEOUT_CYCLES; FSM=IDLE.
- A CTRL GO write in cycle N asserts the strobe in cycle N+1.
- A response sampled in cycle M gives done_o and BUSY=0 in cycle M+1. RDATA is readable from M+1.
- Minimum GO-to-done_o with zero waitrequest and a next-cycle response is 3 cycles.
- CSR reads have fixed latency 1: csr_readdatavalid_o and data are valid in the cycle after csr_read_i. CSR writes take effect on the next edge.
- All outputs are registered.

## Test plan
- Read, ADDR=0x0010, BE=0xF, slave waitrequest 2 cycles then readdata 0x1234_ABCD with resp 0 -> cs_read_o high 3 cycles; RDATA=0x1234ABCD, STATUS DONE=1, RESP=0, one done_o pulse.
- Write, WDATA=0xDEADBEEF, immediate accept, writerespvalid after 5 cycles with resp 2'b10 -> RESP=2, TIMEOUT=0, RDATA unchanged.
- Read, TO_LIMIT=20, slave never responds -> TIMEOUT=1, RDATA=0xFFFFFFFF, RESP=2 at cycle 21 after GO. A late readdatavalid then makes STRAY=1.
- Response arriving in the exact timeout cycle -> normal completion, TIMEOUT=0.
- GO while BUSY -> GO_ERR=1 and a single command. W1C on bits 1-3 clears DONE, TIMEOUT and GO_ERR.
- rstn_i low mid-REQ -> strobes 0 asynchronously, STATUS=0. Then a normal read succeeds.

Source files
------------

// File: rtl/cfg_access_initiator.sv
// cfg_access_initiator
// Launches single Avalon-MM configuration reads/writes into the P-tile config
// slave on behalf of software, guarded by a programmable timeout. Software
// drives everything through a small word-addressed CSR block.
module cfg_access_initiator #(
  parameter int ADDR_WIDTH     = 14,
  parameter int DATA_WIDTH     = 32,
  parameter int RESP_WIDTH     = 2,
  parameter int CSR_ADDR_WIDTH = 8,
  parameter int CSR_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic [CSR_ADDR_WIDTH-1:0]   csr_address_i,
  input  logic                        csr_read_i,
  input  logic                        csr_write_i,
  input  logic [CSR_DATA_WIDTH-1:0]   csr_writedata_i,
  input  logic [CSR_DATA_WIDTH/8-1:0] csr_byteenable_i,
  output logic [CSR_DATA_WIDTH-1:0]   csr_readdata_o,
  output logic                        csr_readdatavalid_o,
  output logic                        csr_waitrequest_o,
  output logic [ADDR_WIDTH-1:0]       cs_address_o,
  output logic [DATA_WIDTH-1:0]       cs_writedata_o,
  output logic                        cs_read_o,
  output logic                        cs_write_o,
  output logic [DATA_WIDTH/8-1:0]     cs_byteenable_o,
  output logic                        cs_burstcount_o,
  input  logic                        cs_waitrequest_i,
  input  logic                        cs_readdatavalid_i,
  input  logic                        cs_writerespvalid_i,
  input  logic [DATA_WIDTH-1:0]       cs_readdata_i,
  input  logic [RESP_WIDTH-1:0]       cs_resp_i,
  output logic                        done_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  localparam logic [CSR_ADDR_WIDTH-1:0] REG_ADDR     = CSR_ADDR_WIDTH'(0);
  localparam logic [CSR_ADDR_WIDTH-1:0] REG_WDATA    = CSR_ADDR_WIDTH'(1);
  localparam logic [CSR_ADDR_WIDTH-1:0] REG_CTRL     = CSR_ADDR_WIDTH'(2);
  localparam logic [CSR_ADDR_WIDTH-1:0] REG_STATUS   = CSR_ADDR_WIDTH'(3);
  localparam logic [CSR_ADDR_WIDTH-1:0] REG_RDATA    = CSR_ADDR_WIDTH'(4);
  localparam logic [CSR_ADDR_WIDTH-1:0] REG_TO_LIMIT = CSR_ADDR_WIDTH'(5);

  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);
  localparam logic [15:0]           LIMIT_RST   = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [15:0]             to_limit_q;
  logic [15:0]             to_cnt_q;
  logic                    rnw_q;
  logic                    done_q;
  logic                    timeout_q;
  logic                    go_err_q;
  logic [RESP_WIDTH-1:0]   resp_q;
  logic [7:0]              stray_q;

  logic                    wr_addr;
  logic                    wr_wdata;
  logic                    wr_ctrl;
  logic                    wr_status;
  logic                    wr_limit;
  logic                    go_req;
  logic                    busy;
  logic                    resp_hit;
  logic                    stray_hit;
  logic                    to_hit;
  logic [15:0]             limit_eff;
  logic [16:0]             cnt_next;
  logic [31:0]             status_word;
  logic [CSR_DATA_WIDTH-1:0] rd_mux;
  logic                    unused_csr_be;

  assign csr_waitrequest_o = 1'b0;
  assign cs_burstcount_o   = 1'b1;
  assign unused_csr_be     = ^csr_byteenable_i;

  // Decode CSR strobes, qualifying responses, stray events and timeout expiry
  always_comb begin
    wr_addr   = csr_write_i && (csr_address_i == REG_ADDR);
    wr_wdata  = csr_write_i && (csr_address_i == REG_WDATA);
    wr_ctrl   = csr_write_i && (csr_address_i == REG_CTRL);
    wr_status = csr_write_i && (csr_address_i == REG_STATUS);
    wr_limit  = csr_write_i && (csr_address_i == REG_TO_LIMIT);
    go_req    = wr_ctrl && csr_writedata_i[0];
    busy      = (state_q == ST_REQ) || (state_q == ST_RESP);
    resp_hit  = (state_q == ST_RESP) &&
                (rnw_q ? cs_readdatavalid_i : cs_writerespvalid_i);
    if (state_q == ST_RESP) begin
      stray_hit = rnw_q ? cs_writerespvalid_i : cs_readdatavalid_i;
    end else begin
      stray_hit = cs_readdatavalid_i || cs_writerespvalid_i;
    end
    limit_eff = (to_limit_q == 16'd0) ? 16'd1 : to_limit_q;
    cnt_next  = {1'b0, to_cnt_q} + 17'd1;
    to_hit    = busy && (cnt_next == {1'b0, limit_eff});
  end

  // Software-owned command registers, frozen while a command is in flight
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      to_limit_q <= LIMIT_RST;
    end else if (!busy) begin
      if (wr_addr)  addr_q     <= csr_writedata_i[ADDR_WIDTH-1:0];
      if (wr_wdata) wdata_q    <= csr_writedata_i[DATA_WIDTH-1:0];
      if (wr_limit) to_limit_q <= csr_writedata_i[15:0];
    end
  end

  // Command FSM with status bookkeeping; FSM-driven sets override W1C clears
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q         <= ST_IDLE;
      cs_address_o    <= '0;
      cs_writedata_o  <= '0;
      cs_byteenable_o <= '0;
      cs_read_o       <= 1'b0;
      cs_write_o      <= 1'b0;
      done_o          <= 1'b0;
      rnw_q           <= 1'b0;
      rdata_q         <= '0;
      to_cnt_q        <= '0;
      done_q          <= 1'b0;
      timeout_q       <= 1'b0;
      go_err_q        <= 1'b0;
      resp_q          <= '0;
      stray_q         <= '0;
    end else begin
      done_o <= 1'b0;

      if (wr_status) begin
        if (csr_writedata_i[1]) done_q    <= 1'b0;
        if (csr_writedata_i[2]) timeout_q <= 1'b0;
        if (csr_writedata_i[3]) go_err_q  <= 1'b0;
      end

      if (wr_status && csr_writedata_i[16]) begin
        stray_q <= '0;
      end else if (stray_hit && (stray_q != 8'hFF)) begin
        stray_q <= stray_q + 8'd1;
      end

      if (go_req && busy) begin
        go_err_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          if (go_req) begin
            state_q         <= ST_REQ;
            rnw_q           <= csr_writedata_i[1];
            cs_read_o       <= csr_writedata_i[1];
            cs_write_o      <= !csr_writedata_i[1];
            cs_address_o    <= addr_q;
            cs_writedata_o  <= wdata_q;
            cs_byteenable_o <= csr_writedata_i[4 +: BE_WIDTH];
            to_cnt_q        <= '0;
            done_q          <= 1'b0;
            timeout_q       <= 1'b0;
            resp_q          <= '0;
          end
        end
        ST_REQ: begin
          to_cnt_q <= cnt_next[15:0];
          if (to_hit) begin
            cs_read_o  <= 1'b0;
            cs_write_o <= 1'b0;
            timeout_q  <= 1'b1;
            resp_q     <= RESP_SLVERR;
            if (rnw_q) rdata_q <= '1;
            done_q     <= 1'b1;
            done_o     <= 1'b1;
            state_q    <= ST_DONE;
          end else if (!cs_waitrequest_i) begin
            cs_read_o  <= 1'b0;
            cs_write_o <= 1'b0;
            state_q    <= ST_RESP;
          end
        end
        ST_RESP: begin
          to_cnt_q <= cnt_next[15:0];
          if (resp_hit) begin
            if (rnw_q) rdata_q <= cs_readdata_i;
            resp_q  <= cs_resp_i;
            done_q  <= 1'b1;
            done_o  <= 1'b1;
            state_q <= ST_DONE;
          end else if (to_hit) begin
            timeout_q <= 1'b1;
            resp_q    <= RESP_SLVERR;
            if (rnw_q) rdata_q <= '1;
            done_q    <= 1'b1;
            done_o    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Assemble the CSR read word for the addressed register
  always_comb begin
    status_word        = '0;
    status_word[0]     = busy;
    status_word[1]     = done_q;
    status_word[2]     = timeout_q;
    status_word[3]     = go_err_q;
    status_word[5:4]   = 2'(resp_q);
    status_word[15:8]  = stray_q;
    rd_mux = '0;
    case (csr_address_i)
      REG_ADDR:     rd_mux = CSR_DATA_WIDTH'(addr_q);
      REG_WDATA:    rd_mux = CSR_DATA_WIDTH'(wdata_q);
      REG_STATUS:   rd_mux = CSR_DATA_WIDTH'(status_word);
      REG_RDATA:    rd_mux = CSR_DATA_WIDTH'(rdata_q);
      REG_TO_LIMIT: rd_mux = CSR_DATA_WIDTH'(to_limit_q);
      default:      rd_mux = '0;
    endcase
  end

  // Fixed one-cycle CSR read return
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      csr_readdata_o      <= '0;
      csr_readdatavalid_o <= 1'b0;
    end else begin
      csr_readdatavalid_o <= csr_read_i;
      csr_readdata_o      <= csr_read_i ? rd_mux : '0;
    end
  end

endmodule
